// File: rtl/boxhead_pkg.sv
// Shared game constants: enemy count, sprite requester slot map and palette index type.
package boxhead_pkg;

  localparam int unsigned ENEMY_NUM         = 4;

  // Sprite ROM requester slots; enemies occupy SLOT_ENEMY0 .. SLOT_ENEMY0+ENEMY_NUM-1.
  localparam int unsigned SLOT_PLAYER       = 0;
  localparam int unsigned SLOT_ATTACK       = 1;
  localparam int unsigned SLOT_ENEMY_ATTACK = 2;
  localparam int unsigned SLOT_ENEMY0       = 3;
  localparam int unsigned N_SLOTS           = SLOT_ENEMY0 + ENEMY_NUM;

  // Palette index returned by the sprite ROM; 0 is transparent.
  localparam int unsigned PAL_W             = 5;
  typedef logic [PAL_W-1:0] palette_idx_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// Combinational round-robin one-hot selector.
// Ports: req     - candidate requests
//        ptr     - last granted slot; search starts at (ptr+1) mod N
//        gnt_oh  - one-hot winner (zero if no request)
//        gnt_idx - binary index of the winner
//        any     - a winner exists
module rr_picker #(
  parameter int unsigned N     = 7,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  // Walk slots ptr+1, ptr+2, ... wrapping; first requester found wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = PTR_W'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among the sprite requesters (player, attack,
// enemy attack, enemies) with round-robin arbitration and a pipelined return path.
// Ports: Clk, Reset_n     - clock, async active-low reset
//        frame_start      - one-cycle pulse at VGA frame start
//        req / req_addr   - per-requester read request and address
//        gnt              - one-hot grant pulse, aligned with rom_rd/rom_addr
//        rom_addr, rom_rd - registered ROM read port
//        rom_data         - ROM palette index, valid RD_LAT cycles after rom_rd
//        rvalid / rdata   - one-hot return tag and returned palette index
//        grant_cnt        - grants issued in the previous frame (saturating)
module sprite_rom_arbiter
  import boxhead_pkg::*;
#(
  parameter int unsigned N_REQ  = N_SLOTS,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_start,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
  output logic [N_REQ-1:0]              gnt,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic                          rom_rd,
  input  palette_idx_t                  rom_data,
  output logic [N_REQ-1:0]              rvalid,
  output palette_idx_t                  rdata,
  output logic [15:0]                   grant_cnt
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TAG_W = RD_LAT * N_REQ;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  pick_oh;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d, grant_cnt_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [TAG_W-1:0]  tag_pipe;

  // A requester being granted this cycle is masked, unless it is the only one asking.
  always_comb begin
    eligible = req & ~gnt;
    if (eligible == '0) eligible = req;
  end

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Pointer, frame counter and address next-state; frame_start overrides the pointer
  // update but the grant made in that cycle still goes out and counts in the new frame.
  always_comb begin
    ptr_d       = ptr_q;
    frame_cnt_d = frame_cnt_q;
    grant_cnt_d = grant_cnt;
    rom_addr_d  = rom_addr;
    if (pick_any) begin
      ptr_d      = pick_idx;
      rom_addr_d = req_addr[pick_idx];
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    if (frame_start) begin
      ptr_d       = PTR_RST;
      grant_cnt_d = frame_cnt_q;
      frame_cnt_d = CNT_W'(pick_any);
    end
  end

  // Registered read port, pointer, counters and return-tag shift pipeline.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt         <= '0;
      rom_rd      <= 1'b0;
      rom_addr    <= '0;
      ptr_q       <= PTR_RST;
      frame_cnt_q <= '0;
      grant_cnt   <= '0;
      tag_pipe    <= '0;
    end else begin
      gnt         <= pick_oh;
      rom_rd      <= pick_any;
      rom_addr    <= rom_addr_d;
      ptr_q       <= ptr_d;
      frame_cnt_q <= frame_cnt_d;
      grant_cnt   <= grant_cnt_d;
      tag_pipe    <= TAG_W'({tag_pipe, gnt});
    end
  end

  // Oldest tag stage lines up with rom_data; the ROM already registers its output,
  // so the data is gated by the tag rather than re-registered.
  assign rvalid = tag_pipe[TAG_W-1 -: N_REQ];
  assign rdata  = (|rvalid) ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed testbench for sprite_rom_arbiter with a 2-cycle sprite ROM model.
module tb_sprite_rom_arbiter;

  localparam int unsigned N      = 7;
  localparam int unsigned AW     = 16;

  logic                 Clk;
  logic                 Reset_n;
  logic                 frame_start;
  logic [N-1:0]         req;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0]         gnt;
  logic [AW-1:0]        rom_addr;
  logic                 rom_rd;
  logic [4:0]           rom_data;
  logic [N-1:0]         rvalid;
  logic [4:0]           rdata;
  logic [15:0]          grant_cnt;

  int n_vec;
  int n_err;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .RD_LAT(2)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .grant_cnt   (grant_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [4:0] rom_fn(input logic [15:0] a);
    return a[4:0] ^ a[12:8];
  endfunction

  function automatic logic [15:0] addr_of(input int i);
    if (i == 0) return 16'h0123;
    return 16'(16'h0415 * i);
  endfunction

  // Sprite ROM: two register stages between rom_rd and rom_data.
  logic [4:0] rom_s1, rom_s2;
  always @(posedge Clk) begin
    rom_s1 <= rom_rd ? rom_fn(rom_addr) : 5'd0;
    rom_s2 <= rom_s1;
  end
  assign rom_data = rom_s2;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    req         = '0;
    for (int i = 0; i < int'(N); i++) req_addr[i] = addr_of(i);
    tick();
    tick();
    n_vec++; if (gnt !== 7'd0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_vec++; if (rvalid !== 7'd0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_vec++; if (rom_rd !== 1'b0) begin n_err++; $display("FAIL reset_rom_rd: got %b want 0", rom_rd); end
    n_vec++; if (rom_addr !== 16'h0) begin n_err++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_vec++; if (rdata !== 5'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_vec++; if (grant_cnt !== 16'h0) begin n_err++; $display("FAIL reset_grant_cnt: got %h want 0", grant_cnt); end
    Reset_n = 1'b1;
  endtask

  task automatic test_single();
    req = 7'b0000001;
    tick();
    req = '0;
    n_vec++; if (gnt !== 7'b0000001) begin n_err++; $display("FAIL single_gnt: got %b want 0000001", gnt); end
    n_vec++; if (rom_rd !== 1'b1) begin n_err++; $display("FAIL single_rom_rd: got %b want 1", rom_rd); end
    n_vec++; if (rom_addr !== 16'h0123) begin n_err++; $display("FAIL single_rom_addr: got %h want 0123", rom_addr); end
    tick();
    n_vec++; if (gnt !== 7'd0 || rom_rd !== 1'b0) begin n_err++; $display("FAIL single_idle: got gnt=%b rd=%b want 0/0", gnt, rom_rd); end
    n_vec++; if (rvalid !== 7'd0) begin n_err++; $display("FAIL single_early_rvalid: got %b want 0", rvalid); end
    tick();
    n_vec++; if (rvalid !== 7'b0000001) begin n_err++; $display("FAIL single_rvalid: got %b want 0000001", rvalid); end
    n_vec++; if (rdata !== 5'h02) begin n_err++; $display("FAIL single_rdata: got %h want 02", rdata); end
    tick();
    n_vec++; if (rvalid !== 7'd0) begin n_err++; $display("FAIL single_rvalid_off: got %b want 0", rvalid); end
  endtask

  task automatic test_all_seven();
    logic [N-1:0] gexp, vexp;
    logic [4:0]   dexp;
    int           s;
    // frame_start with no requests puts the pointer at slot 6 and publishes the 1 prior grant.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++; if (grant_cnt !== 16'd1) begin n_err++; $display("FAIL seven_prev_cnt: got %0d want 1", grant_cnt); end
    req = '1;
    for (int k = 0; k < 10; k++) begin
      tick();
      gexp = (k < 8) ? (7'd1 << (k % 7)) : 7'd0;
      vexp = 7'd0;
      dexp = 5'd0;
      if (k >= 2) begin
        s    = (k - 2) % 7;
        vexp = 7'd1 << s;
        dexp = rom_fn(addr_of(s));
      end
      n_vec++; if (gnt !== gexp) begin n_err++; $display("FAIL seven_gnt[%0d]: got %b want %b", k, gnt, gexp); end
      n_vec++; if (rvalid !== vexp || rdata !== dexp) begin n_err++; $display("FAIL seven_rvalid[%0d]: got %b/%h want %b/%h", k, rvalid, rdata, vexp, dexp); end
      if (k == 7) req = '0;
    end
  endtask

  task automatic test_frame_restart();
    req = '1;
    tick();
    n_vec++; if (gnt !== 7'b0000010) begin n_err++; $display("FAIL restart_gnt1: got %b want 0000010", gnt); end
    tick();
    n_vec++; if (gnt !== 7'b0000100) begin n_err++; $display("FAIL restart_gnt2: got %b want 0000100", gnt); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++; if (gnt !== 7'b0001000) begin n_err++; $display("FAIL restart_gnt3: got %b want 0001000", gnt); end
    n_vec++; if (grant_cnt !== 16'd10) begin n_err++; $display("FAIL restart_cnt: got %0d want 10", grant_cnt); end
    tick();
    n_vec++; if (gnt !== 7'b0000001) begin n_err++; $display("FAIL restart_player_first: got %b want 0000001", gnt); end
    tick();
    req = '0;
    n_vec++; if (gnt !== 7'b0000010) begin n_err++; $display("FAIL restart_gnt_after: got %b want 0000010", gnt); end
    n_vec++; if (rvalid !== 7'b0001000 || rdata !== rom_fn(addr_of(3))) begin n_err++; $display("FAIL restart_inflight: got %b/%h want 0001000/%h", rvalid, rdata, rom_fn(addr_of(3))); end
    tick();
    tick();
    n_vec++; if (rvalid !== 7'b0000010) begin n_err++; $display("FAIL restart_last_rvalid: got %b want 0000010", rvalid); end
  endtask

  task automatic test_saturate();
    int grants;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++; if (grant_cnt !== 16'd3) begin n_err++; $display("FAIL sat_prev_cnt: got %0d want 3", grant_cnt); end
    grants = 0;
    req = 7'b0000011;
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (gnt != 7'd0) grants++;
    end
    req = '0;
    n_vec++; if (grants !== 70000) begin n_err++; $display("FAIL sat_throughput: got %0d want 70000", grants); end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++; if (grant_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt: got %h want FFFF", grant_cnt); end
    req = 7'b0000011;
    tick();
    tick();
    tick();
    req = '0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++; if (grant_cnt !== 16'd3) begin n_err++; $display("FAIL sat_restart_cnt: got %0d want 3", grant_cnt); end
  endtask

  task automatic test_reset_flush();
    tick();
    tick();
    req = 7'b0000110;
    tick();
    tick();
    req = '0;
    Reset_n = 1'b0;
    #1;
    n_vec++; if (gnt !== 7'd0 || rom_rd !== 1'b0 || rvalid !== 7'd0) begin n_err++; $display("FAIL flush_async: got gnt=%b rd=%b rvalid=%b want 0", gnt, rom_rd, rvalid); end
    tick();
    tick();
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (rvalid !== 7'd0) begin n_err++; $display("FAIL flush_rvalid[%0d]: got %b want 0", k, rvalid); end
    end
    req = '1;
    tick();
    req = '0;
    n_vec++; if (gnt !== 7'b0000001) begin n_err++; $display("FAIL flush_first_gnt: got %b want 0000001", gnt); end
    tick();
    tick();
    n_vec++; if (rvalid !== 7'b0000001 || rdata !== 5'h02) begin n_err++; $display("FAIL flush_new_read: got %b/%h want 0000001/02", rvalid, rdata); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_all_seven();
    test_frame_restart();
    test_saturate();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 7, meaning the requester count: slot 0 player, 1 attack, 2 enemy_attack, 3..6 enemy[0..3] (3+ENEMY_NUM).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the sprite ROM word-address width.
REQ-003 SHALL have parameter RD_LAT, default 2, meaning the ROM read latency in clocks, legal range 1..4.
REQ-004 SHALL have port Clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port frame_start, input, 1, a one-cycle pulse at the start of each VGA frame.
REQ-007 SHALL have port req, input, N_REQ, the per-requester read request, held high until granted.
REQ-008 SHALL have port req_addr, input, N_REQ x ADDR_W, the per-requester address, stable while req is high.
REQ-009 SHALL have port gnt, output, N_REQ, a one-hot one-cycle grant pulse.
REQ-010 SHALL have port rom_addr, output, ADDR_W, the shared ROM address, registered.
REQ-011 SHALL have port rom_rd, output, 1, the ROM read strobe, registered.
REQ-012 SHALL have port rom_data, input, 5, the palette index returned by the ROM RD_LAT cycles after rom_rd.
REQ-013 SHALL have port rvalid, output, N_REQ, a one-hot one-cycle pulse marking whose data is on rdata.
REQ-014 SHALL have port rdata, output, 5, the returned palette index (0 = transparent).
REQ-015 SHALL have port grant_cnt, output, 16, the number of grants issued in the previous frame, saturating.

Function
REQ-016 SHALL grant at most one requester per cycle, round-robin, searching upward from slot (last_granted+1) mod N_REQ.
REQ-017 SHALL assert gnt[i], rom_rd=1 and rom_addr=req_addr[i] in the same cycle, one clock after arbitration sees req[i] high.
REQ-018 SHALL treat a requester as granted once gnt[i] pulses; the requester drops req the next cycle or it is re-arbitrated as a new request.
REQ-019 SHALL ignore req[i] while gnt[i]=1 that cycle, so no requester receives back-to-back grants unless it is the only one requesting.
REQ-020 SHALL carry a one-hot tag through an RD_LAT-deep shift pipeline and pulse rvalid exactly RD_LAT cycles after the matching rom_rd, with rdata=rom_data.
REQ-021 SHALL sustain one grant per cycle with any number of reads in flight (full pipelining, no stall).
REQ-022 SHALL, when req is all zero, drive rom_rd=0 and gnt=0 and leave the round-robin pointer unchanged.
REQ-023 SHALL reset the pointer on frame_start so slot 0 (player) has top priority in the next arbitration; a grant in the same cycle completes normally.
REQ-024 SHALL count grants in a 16-bit frame counter saturating at 0xFFFF, copy it to grant_cnt on frame_start and clear it to 0 (or 1 if a grant coincides).
REQ-025 SHALL deliver rvalid for in-flight reads even if frame_start occurs during them.
REQ-026 SHALL wrap the pointer from N_REQ-1 to 0.

Reset
REQ-027 SHALL, while Reset_n=0, force gnt=0, rvalid=0, rom_rd=0, rom_addr=0, rdata=0, grant_cnt=0, pointer=N_REQ-1, counter=0, tag pipeline empty.
REQ-028 SHALL discard reads in flight at reset assertion, issuing no rvalid for them after release.

Structure
REQ-029 SHALL take ENEMY_NUM, the requester slot indices and the 5-bit palette-index type from a shared package boxhead_pkg.
REQ-030 SHALL contain one sub-module rr_picker, a combinational round-robin one-hot selector with a pointer input.

Verification
REQ-031 SHALL verify single request: req=0000001, addr 0x0123 -> next cycle gnt[0], rom_addr=0x0123; RD_LAT=2 later rvalid[0], rdata=ROM[0x0123].
REQ-032 SHALL verify all seven held with pointer 6: grants in order 0,1,2,3,4,5,6,0 on consecutive cycles, rvalid in the same order lagging by 2.
REQ-033 SHALL verify frame_start mid-stream after granting slot 3 with all requesting: the next grant is slot 0, not 4.
REQ-034 SHALL verify 70000 grants in one frame: grant_cnt=0xFFFF after frame_start, the counter restarts at 0.
REQ-035 SHALL verify Reset_n low with 2 reads in flight: no rvalid after release; the first grant after release goes to slot 0.
